// File: rtl/sram_oq_scheduler.sv
// Shared SRAM port scheduler: arbitrates input writes against round-robin output reads
// and tracks per-queue pointers and occupancy. Optional read anti-starvation: SRAM_OQ_RD_ANTISTARVE_EN.
module sram_oq_scheduler #(
    parameter int NUM_QUEUES     = 5,
    parameter int QUEUE_ID_WIDTH = 3,
    parameter int MEM_ADDR_WIDTH = 19,
    parameter int QUEUE_SIZE     = 104857,
    parameter int WR_BURST_MAX   = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_valid,
    input  logic [QUEUE_ID_WIDTH-1:0]            wr_queue,
    input  logic                                 wr_last,
    input  logic                                 wr_drop,
    output logic                                 wr_ready,
    input  logic [NUM_QUEUES-1:0]                oq_afull,
    output logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] free_words,
    output logic [NUM_QUEUES-1:0]                oq_nonempty,
    output logic                                 mem_cmd_valid,
    output logic                                 mem_cmd_we,
    output logic [MEM_ADDR_WIDTH-1:0]            mem_cmd_addr,
    output logic [QUEUE_ID_WIDTH-1:0]            mem_cmd_queue,
    input  logic                                 mem_cmd_ready
);
    localparam int AW = MEM_ADDR_WIDTH;
    localparam int QW = QUEUE_ID_WIDTH;
    localparam logic [AW-1:0] QSIZE = AW'(QUEUE_SIZE);
    localparam logic [AW-1:0] QLAST = AW'(QUEUE_SIZE - 1);

    logic [AW-1:0] head_q  [NUM_QUEUES];
    logic [AW-1:0] head_d  [NUM_QUEUES];
    logic [AW-1:0] tail_q  [NUM_QUEUES];
    logic [AW-1:0] tail_d  [NUM_QUEUES];
    logic [AW-1:0] ctail_q [NUM_QUEUES];
    logic [AW-1:0] ctail_d [NUM_QUEUES];
    logic [AW-1:0] used_q  [NUM_QUEUES];
    logic [AW-1:0] used_d  [NUM_QUEUES];
    logic [AW-1:0] avail_q [NUM_QUEUES];
    logic [AW-1:0] avail_d [NUM_QUEUES];
    logic [AW-1:0] pend_q  [NUM_QUEUES];
    logic [AW-1:0] pend_d  [NUM_QUEUES];
    logic [AW-1:0] free_q  [NUM_QUEUES];
    logic [AW-1:0] free_d  [NUM_QUEUES];

    logic [NUM_QUEUES-1:0] nonempty_q, nonempty_d;
    logic [QW-1:0]         rr_q, rr_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic                  cmd_we_q, cmd_we_d;
    logic [AW-1:0]         cmd_addr_q, cmd_addr_d;
    logic [QW-1:0]         cmd_queue_q, cmd_queue_d;

    logic                  cmd_free;
    logic                  wq_ok;
    logic                  wr_elig;
    logic [AW-1:0]         wr_used_sel;
    logic [AW-1:0]         wr_addr;
    logic [NUM_QUEUES-1:0] rd_elig;
    logic                  rd_found;
    logic [QW-1:0]         rd_q;
    logic [AW-1:0]         rd_addr;
    logic                  force_rd;
    logic                  wr_grant;
    logic                  rd_grant;
    logic                  drop_act;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == QLAST) ? '0 : p + 1'b1;
    endfunction

    // Write-side selection: occupancy and absolute address of the addressed queue.
    always_comb begin
        wq_ok       = int'(wr_queue) < NUM_QUEUES;
        wr_used_sel = '0;
        wr_addr     = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (wr_queue == QW'(i)) begin
                wr_used_sel = used_q[i];
                wr_addr     = AW'(i * QUEUE_SIZE) + tail_q[i];
            end
        end
        wr_elig = wr_valid && !wr_drop && wq_ok && (wr_used_sel < QSIZE);
    end

    // Round-robin read selection starting at rr_q.
    always_comb begin
        int idx;
        rd_found = 1'b0;
        rd_q     = '0;
        rd_addr  = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            rd_elig[i] = (avail_q[i] != '0) && !oq_afull[i];
        end
        for (int k = 0; k < NUM_QUEUES; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
            if (!rd_found && rd_elig[idx]) begin
                rd_found = 1'b1;
                rd_q     = QW'(idx);
                rd_addr  = AW'(idx * QUEUE_SIZE) + head_q[idx];
            end
        end
    end

`ifdef SRAM_OQ_RD_ANTISTARVE_EN
    localparam int BW = $clog2(WR_BURST_MAX + 1);
    logic [BW-1:0] burst_q, burst_d;

    assign force_rd = (burst_q >= BW'(WR_BURST_MAX)) && rd_found;

    always_comb begin
        burst_d = burst_q;
        if (cmd_free) begin
            if (rd_grant || !rd_found) burst_d = '0;
            else if (wr_grant)         burst_d = burst_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) burst_q <= '0;
        else        burst_q <= burst_d;
    end
`else
    assign force_rd = 1'b0;
`endif

    // Nothing moves while a previously issued command is still waiting for acceptance.
    assign cmd_free = !cmd_valid_q || mem_cmd_ready;
    assign wr_grant = cmd_free && wr_elig && !force_rd;
    assign rd_grant = cmd_free && rd_found && !wr_grant;
    assign drop_act = cmd_free && wr_drop && wq_ok;
    assign wr_ready = wr_grant;

    always_comb begin
        logic is_w, is_r, is_d;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            head_d[i]  = head_q[i];
            tail_d[i]  = tail_q[i];
            ctail_d[i] = ctail_q[i];
            used_d[i]  = used_q[i];
            avail_d[i] = avail_q[i];
            pend_d[i]  = pend_q[i];
            is_w = wr_grant && (wr_queue == QW'(i));
            is_r = rd_grant && (rd_q == QW'(i));
            is_d = drop_act && (wr_queue == QW'(i));
            if (is_w) begin
                tail_d[i] = ptr_inc(tail_q[i]);
                used_d[i] = used_q[i] + 1'b1;
                if (wr_last) begin
                    avail_d[i] = avail_q[i] + pend_q[i] + 1'b1;
                    pend_d[i]  = '0;
                    ctail_d[i] = ptr_inc(tail_q[i]);
                end else begin
                    pend_d[i] = pend_q[i] + 1'b1;
                end
            end
            if (is_d) begin
                tail_d[i] = ctail_q[i];
                used_d[i] = used_q[i] - pend_q[i];
                pend_d[i] = '0;
            end
            // A read on a queue being dropped still retires its committed word.
            if (is_r) begin
                head_d[i]  = ptr_inc(head_q[i]);
                used_d[i]  = used_d[i] - 1'b1;
                avail_d[i] = avail_q[i] - 1'b1;
            end
            free_d[i]     = QSIZE - used_d[i];
            nonempty_d[i] = avail_d[i] != '0;
        end
    end

    always_comb begin
        rr_d        = rr_q;
        cmd_valid_d = cmd_valid_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_queue_d = cmd_queue_q;
        if (rd_grant) begin
            rr_d = (rd_q == QW'(NUM_QUEUES - 1)) ? '0 : rd_q + 1'b1;
        end
        if (cmd_free) begin
            cmd_valid_d = wr_grant || rd_grant;
            cmd_we_d    = wr_grant;
            cmd_addr_d  = wr_grant ? wr_addr : (rd_grant ? rd_addr : '0);
            cmd_queue_d = wr_grant ? wr_queue : (rd_grant ? rd_q : '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                ctail_q[i] <= '0;
                used_q[i]  <= '0;
                avail_q[i] <= '0;
                pend_q[i]  <= '0;
                free_q[i]  <= QSIZE;
            end
            nonempty_q  <= '0;
            rr_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_queue_q <= '0;
        end else begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                head_q[i]  <= head_d[i];
                tail_q[i]  <= tail_d[i];
                ctail_q[i] <= ctail_d[i];
                used_q[i]  <= used_d[i];
                avail_q[i] <= avail_d[i];
                pend_q[i]  <= pend_d[i];
                free_q[i]  <= free_d[i];
            end
            nonempty_q  <= nonempty_d;
            rr_q        <= rr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_queue_q <= cmd_queue_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_free
            assign free_words[gi*AW +: AW] = free_q[gi];
        end
    endgenerate

    assign oq_nonempty   = nonempty_q;
    assign mem_cmd_valid = cmd_valid_q;
    assign mem_cmd_we    = cmd_we_q;
    assign mem_cmd_addr  = cmd_addr_q;
    assign mem_cmd_queue = cmd_queue_q;

endmodule

// File: tb/tb_sram_oq_scheduler.sv
// Directed bench for sram_oq_scheduler with 8-word regions; expected values are hand-computed.
// Anti-starvation expectations follow SRAM_OQ_RD_ANTISTARVE_EN.
module tb_sram_oq_scheduler;
    localparam int NQ = 5;
    localparam int QW = 3;
    localparam int AW = 19;
    localparam int QS = 8;
    localparam int WB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_valid = 1'b0;
    logic [QW-1:0] wr_queue = '0;
    logic          wr_last = 1'b0;
    logic          wr_drop = 1'b0;
    logic          wr_ready;
    logic [NQ-1:0] oq_afull = '1;
    logic [NQ*AW-1:0] free_words;
    logic [NQ-1:0] oq_nonempty;
    logic          mem_cmd_valid;
    logic          mem_cmd_we;
    logic [AW-1:0] mem_cmd_addr;
    logic [QW-1:0] mem_cmd_queue;
    logic          mem_cmd_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sram_oq_scheduler #(
        .NUM_QUEUES(NQ), .QUEUE_ID_WIDTH(QW), .MEM_ADDR_WIDTH(AW),
        .QUEUE_SIZE(QS), .WR_BURST_MAX(WB)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_queue(wr_queue), .wr_last(wr_last), .wr_drop(wr_drop),
        .wr_ready(wr_ready), .oq_afull(oq_afull), .free_words(free_words),
        .oq_nonempty(oq_nonempty), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_we(mem_cmd_we),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_queue(mem_cmd_queue), .mem_cmd_ready(mem_cmd_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fw(input int q);
        return 32'(free_words[q*AW +: AW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_write(input int q, input logic last, input int exp_addr);
        wr_valid = 1'b1;
        wr_queue = QW'(q);
        wr_last  = last;
        #1;
        check_eq("wr_ready", 32'(wr_ready), 32'd1);
        tick();
        check_eq("wr_cmd_valid", 32'(mem_cmd_valid), 32'd1);
        check_eq("wr_cmd_we", 32'(mem_cmd_we), 32'd1);
        check_eq("wr_cmd_addr", 32'(mem_cmd_addr), 32'(exp_addr));
        $display("write q%0d last=%0d addr=%0d", q, last, mem_cmd_addr);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic expect_read(input int exp_addr, input int exp_q);
        tick();
        check_eq("rd_cmd_valid", 32'(mem_cmd_valid), 32'd1);
        check_eq("rd_cmd_we", 32'(mem_cmd_we), 32'd0);
        check_eq("rd_cmd_addr", 32'(mem_cmd_addr), 32'(exp_addr));
        check_eq("rd_cmd_queue", 32'(mem_cmd_queue), 32'(exp_q));
        $display("read q%0d addr=%0d", mem_cmd_queue, mem_cmd_addr);
    endtask

    initial begin
        int exp_addr[8];
        logic exp_we[8];
        int n_rd;

        // Reset state while held in reset
        #12;
        check_eq("rst_cmd_valid", 32'(mem_cmd_valid), 32'd0);
        check_eq("rst_free0", fw(0), 32'(QS));
        check_eq("rst_free4", fw(4), 32'(QS));
        check_eq("rst_nonempty", 32'(oq_nonempty), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Three-word packet to q2; visible only after commit
        do_write(2, 1'b0, 16);
        do_write(2, 1'b0, 17);
        check_eq("q2_not_visible", 32'(oq_nonempty[2]), 32'd0);
        do_write(2, 1'b1, 18);
        check_eq("q2_visible", 32'(oq_nonempty[2]), 32'd1);
        check_eq("q2_free", fw(2), 32'd5);
        oq_afull = 5'b11011;
        expect_read(16, 2);
        expect_read(17, 2);
        expect_read(18, 2);
        check_eq("q2_drained", 32'(oq_nonempty[2]), 32'd0);
        check_eq("q2_free_back", fw(2), 32'(QS));
        oq_afull = '1;
        tick();
        check_eq("idle_cmd_valid", 32'(mem_cmd_valid), 32'd0);

        // Fill q0, full back-pressure, then wrap after one read
        for (int k = 0; k < QS; k++) do_write(0, (k == QS - 1), k);
        check_eq("q0_full_free", fw(0), 32'd0);
        wr_valid = 1'b1; wr_queue = 3'd0; wr_last = 1'b1;
        oq_afull = 5'b11110;
        #1;
        check_eq("q0_full_wr_ready", 32'(wr_ready), 32'd0);
        expect_read(0, 0);
        oq_afull = '1;
        #1;
        check_eq("q0_wrap_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        check_eq("q0_wrap_we", 32'(mem_cmd_we), 32'd1);
        check_eq("q0_wrap_addr", 32'(mem_cmd_addr), 32'd0);
        $display("write q0 last=1 addr=%0d", mem_cmd_addr);
        wr_valid = 1'b0; wr_last = 1'b0;
        check_eq("q0_wrap_free", fw(0), 32'd0);

        // Round-robin between q1 and q3, then q3 blocked
        for (int k = 0; k < 4; k++) do_write(1, (k == 3), 8 + k);
        for (int k = 0; k < 4; k++) do_write(3, (k == 3), 24 + k);
        oq_afull = 5'b10101;
        expect_read(8, 1);
        expect_read(24, 3);
        expect_read(9, 1);
        expect_read(25, 3);
        oq_afull = 5'b11101;
        expect_read(10, 1);
        expect_read(11, 1);
        tick();
        check_eq("q3_blocked_idle", 32'(mem_cmd_valid), 32'd0);
        oq_afull = 5'b10111;
        expect_read(26, 3);
        expect_read(27, 3);
        oq_afull = '1;

        // Drop of an open packet on q4
        do_write(4, 1'b0, 32);
        do_write(4, 1'b0, 33);
        check_eq("q4_open_free", fw(4), 32'd6);
        check_eq("q4_open_nonempty", 32'(oq_nonempty[4]), 32'd0);
        wr_valid = 1'b1; wr_queue = 3'd4; wr_drop = 1'b1;
        #1;
        check_eq("drop_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        wr_valid = 1'b0; wr_drop = 1'b0;
        check_eq("drop_cmd_valid", 32'(mem_cmd_valid), 32'd0);
        check_eq("drop_free", fw(4), 32'(QS));
        check_eq("drop_nonempty", 32'(oq_nonempty[4]), 32'd0);
        do_write(4, 1'b1, 32);
        check_eq("q4_commit_nonempty", 32'(oq_nonempty[4]), 32'd1);

        // Command stall for 5 cycles
        do_write(2, 1'b0, 19);
        mem_cmd_ready = 1'b0;
        wr_valid = 1'b1; wr_queue = 3'd2;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("stall_wr_ready", 32'(wr_ready), 32'd0);
            tick();
            check_eq("stall_valid", 32'(mem_cmd_valid), 32'd1);
            check_eq("stall_addr", 32'(mem_cmd_addr), 32'd19);
            check_eq("stall_free", fw(2), 32'd7);
        end
        mem_cmd_ready = 1'b1;
        do_write(2, 1'b0, 20);
        do_write(2, 1'b1, 21);
        check_eq("post_stall_free", fw(2), 32'd5);
        check_eq("post_stall_nonempty", 32'(oq_nonempty[2]), 32'd1);

        // Continuous writes to q1 while q0 is read-eligible
`ifdef SRAM_OQ_RD_ANTISTARVE_EN
        exp_we   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_addr = '{12, 13, 14, 15, 1, 8, 9, 10};
`else
        exp_we   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_addr = '{12, 13, 14, 15, 8, 9, 10, 11};
`endif
        n_rd = 0;
        oq_afull = 5'b11110;
        wr_valid = 1'b1; wr_queue = 3'd1; wr_last = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_eq("burst_wr_ready", 32'(wr_ready), 32'(exp_we[k]));
            tick();
            check_eq("burst_we", 32'(mem_cmd_we), 32'(exp_we[k]));
            check_eq("burst_addr", 32'(mem_cmd_addr), 32'(exp_addr[k]));
            if (!mem_cmd_we) n_rd++;
            $display("burst cmd %0d we=%0d addr=%0d", k, mem_cmd_we, mem_cmd_addr);
        end
        wr_valid = 1'b0; wr_last = 1'b0;
`ifdef SRAM_OQ_RD_ANTISTARVE_EN
        check_eq("burst_reads", 32'(n_rd), 32'd1);
`else
        check_eq("burst_reads", 32'(n_rd), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
